// File: rtl/uart_baud_ctrl.sv
// Baud divisor controller: shadows bus writes and applies them to the tick generator only when TX and RX are idle.
// Define UART_AUTOBAUD_EN to build the autobaud engine that measures the start bit of a received 0x55.
module uart_baud_ctrl #(
  parameter int DIV_W       = 32,
  parameter int DEFAULT_DIV = 433,
  parameter int MIN_DIV     = 3
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_wr_en,
  input  logic [DIV_W-1:0] i_wr_div,
  input  logic             i_tx_busy,
  input  logic             i_rx_busy,
  input  logic             i_rx,
  input  logic             i_ab_start,
  output logic [DIV_W-1:0] o_baud_sel,
  output logic             o_baud_rstn,
  output logic             o_pending,
  output logic             o_ab_busy,
  output logic             o_ab_done,
  output logic             o_ab_err
);

  localparam logic [DIV_W-1:0] MinDiv     = DIV_W'(MIN_DIV);
  localparam logic [DIV_W-1:0] DefaultDiv = DIV_W'(DEFAULT_DIV);

  logic [DIV_W-1:0] shadow_q, shadow_d;
  logic [DIV_W-1:0] baudSel_q, baudSel_d;
  logic             pending_q, pending_d;
  logic             baudRstn_q, baudRstn_d;
  logic [DIV_W-1:0] cand;
  logic             want;
  logic             abLoad;
  logic [DIV_W-1:0] abDiv;

  // An autobaud result outranks a same-cycle bus write; a write made while idle applies without a bubble.
  always_comb begin
    cand       = shadow_q;
    want       = pending_q;
    baudSel_d  = baudSel_q;
    baudRstn_d = 1'b1;
    if (i_wr_en) begin
      cand = (i_wr_div < MinDiv) ? MinDiv : i_wr_div;
      want = 1'b1;
    end
    if (abLoad) begin
      cand = abDiv;
      want = 1'b1;
    end
    if (want && !i_tx_busy && !i_rx_busy) begin
      baudSel_d  = cand;
      baudRstn_d = 1'b0;
      want       = 1'b0;
    end
    shadow_d  = cand;
    pending_d = want;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      shadow_q   <= DefaultDiv;
      baudSel_q  <= DefaultDiv;
      pending_q  <= 1'b0;
      baudRstn_q <= 1'b1;
    end else begin
      shadow_q   <= shadow_d;
      baudSel_q  <= baudSel_d;
      pending_q  <= pending_d;
      baudRstn_q <= baudRstn_d;
    end
  end

  assign o_baud_sel  = baudSel_q;
  assign o_baud_rstn = baudRstn_q;
  assign o_pending   = pending_q;

`ifdef UART_AUTOBAUD_EN
  typedef enum logic [2:0] {
    AB_IDLE,
    AB_ARM,
    AB_WAIT_FALL,
    AB_MEASURE,
    AB_DONE
  } abState_e;

  abState_e         state_q, state_d;
  logic [1:0]       sync_q;
  logic             rxS;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             abErr_q, abErr_d;
  logic             abDone_q;
  logic             abBusy_q;

  assign rxS = sync_q[1];

  // cnt ends up equal to the number of low rxS samples, i.e. one bit time in clocks.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    abErr_d = abErr_q;
    case (state_q)
      AB_IDLE:      if (i_ab_start) state_d = AB_ARM;
      AB_ARM:       if (rxS) state_d = AB_WAIT_FALL;
      AB_WAIT_FALL: begin
        if (!rxS) begin
          state_d = AB_MEASURE;
          cnt_d   = DIV_W'(1);
        end
      end
      AB_MEASURE: begin
        if (rxS) begin
          state_d = AB_DONE;
          abErr_d = (cnt_q - DIV_W'(1)) < MinDiv;
        end else if (cnt_q == '1) begin
          state_d = AB_DONE;
          abErr_d = 1'b1;
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      AB_DONE: begin
        state_d = AB_IDLE;
        abErr_d = 1'b0;
      end
      default: state_d = AB_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q  <= AB_IDLE;
      sync_q   <= 2'b11;
      cnt_q    <= '0;
      abErr_q  <= 1'b0;
      abDone_q <= 1'b0;
      abBusy_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync_q   <= {sync_q[0], i_rx};
      cnt_q    <= cnt_d;
      abErr_q  <= abErr_d;
      abDone_q <= (state_d == AB_DONE);
      abBusy_q <= (state_d != AB_IDLE);
    end
  end

  assign abLoad    = abDone_q && !abErr_q;
  assign abDiv     = cnt_q - DIV_W'(1);
  assign o_ab_busy = abBusy_q;
  assign o_ab_done = abDone_q;
  assign o_ab_err  = abErr_q;
`else
  logic unusedAb;

  assign unusedAb  = ^{i_rx, i_ab_start};
  assign abLoad    = 1'b0;
  assign abDiv     = '0;
  assign o_ab_busy = 1'b0;
  assign o_ab_done = 1'b0;
  assign o_ab_err  = 1'b0;
`endif

endmodule

// File: doc/uart_baud_ctrl.md
# uart_baud_ctrl

Divisor controller for the UART baud-rate tick generator. Owns the divisor word shared by the TX and RX channels and accepts bus writes at any time. A new divisor reaches the generator only when both channels are idle, and the generator is restarted on every change. An optional autobaud engine measures the start bit of a received 0x55 ('U') character and programs the divisor from it.

## Interface
Parameters:
- DIV_W, 32, divisor width; matches the generator's i_baud_sel.
- DEFAULT_DIV, 433, reset divisor (50 MHz / 115200, minus 1).
- MIN_DIV, 3, smallest divisor ever applied.

Ports:
- i_clk  in  1  clock.
- i_rstn  in  1  reset, asynchronous, active-low.
- i_wr_en  in  1  divisor write strobe, one cycle.
- i_wr_div  in  DIV_W  divisor to write.
- i_tx_busy  in  1  TX channel mid-frame.
- i_rx_busy  in  1  RX channel mid-frame.
- i_rx  in  1  raw serial RX line (autobaud only).
- i_ab_start  in  1  autobaud start pulse.
- o_baud_sel  out  DIV_W  divisor driven to the generator.
- o_baud_rstn  out  1  generator restart, active-low, one-cycle pulse.
- o_pending  out  1  divisor accepted but not yet applied.
- o_ab_busy  out  1  autobaud in progress.
- o_ab_done  out  1  autobaud finished, one-cycle pulse.
- o_ab_err  out  1  autobaud failed; valid with o_ab_done.

## Operation
- Shadow register plus pending flag.
- Write: shadow = max(i_wr_div, MIN_DIV); pending = 1.
- A write while pending is set overwrites the shadow; last write wins.
- Apply: in any cycle where pending=1, i_tx_busy=0 and i_rx_busy=0:
  - next cycle o_baud_sel = shadow, o_baud_rstn = 0 for that one cycle, pending = 0.
- A write in a cycle where both busy inputs are low applies in the next cycle; there is no extra bubble.
- Writing the current value still applies and restarts the generator.
- Autobaud FSM:
  - i_rx passes through a 2-flop synchronizer, giving rx_s.
  - AB_IDLE → AB_ARM on i_ab_start. i_ab_start is ignored in any other state.
  - AB_ARM → AB_WAIT_FALL when rx_s=1. This ensures the line is idle before arming.
  - AB_WAIT_FALL → AB_MEASURE on rx_s=0; cnt = 1.
  - AB_MEASURE: cnt++ while rx_s=0.
    - On rx_s=1 → AB_DONE with N = cnt.
    - If cnt reaches 2^DIV_W−1 with rx_s still 0 → AB_DONE with error.
  - AB_DONE, one cycle: o_ab_done = 1, then → AB_IDLE.
    - Error if saturated or N−1 < MIN_DIV; on error the shadow and pending flag are untouched.
    - Otherwise shadow = N−1, pending = 1. This overrides any pending bus write; a bus write in the same cycle loses.
- o_ab_busy = 1 in every state except AB_IDLE.
- No timeout in AB_ARM or AB_WAIT_FALL; only reset cancels an armed autobaud.

## Timing
- Reset values:
  - o_baud_sel = DEFAULT_DIV, o_baud_rstn = 1, o_pending = 0.
  - o_ab_busy = 0, o_ab_done = 0, o_ab_err = 0.
  - FSM in AB_IDLE; synchronizer flops reset to 1.
- All outputs are registered.
- Write at cycle T with both busy inputs low: o_baud_sel and o_baud_rstn=0 at T+1; o_baud_rstn=1 again at T+2.
- Write at T with a channel busy: o_pending=1 from T+1.
  - Busy inputs first sampled both low at U: apply at U+1, o_pending=0 at U+1.
- Busy inputs are sampled in the same cycle as a write; a busy deassertion coincident with the write applies at T+1.
- Autobaud latency: the rx edge appears at rx_s 2 cycles later.
  - N equals the number of low rx_s cycles.
  - o_ab_done asserts 1 cycle after the rising rx_s sample.
  - Apply follows the normal idle rule, at the earliest the cycle after o_ab_done.
- Reset mid-operation: the pending write and any autobaud are discarded, and o_baud_sel returns to DEFAULT_DIV.

## Configuration
- UART_AUTOBAUD_EN defined: synchronizer and autobaud FSM are present as described.
- UART_AUTOBAUD_EN undefined:
  - No synchronizer or FSM is built.
  - i_rx and i_ab_start are ignored.
  - o_ab_busy, o_ab_done and o_ab_err are tied 0.
  - Divisor writes behave identically.

## Test plan
- Reset with no stimulus → o_baud_sel=433, o_baud_rstn=1, o_pending=0, all autobaud outputs 0.
- Idle, write 16 at T → o_baud_sel=16 and o_baud_rstn=0 at T+1; o_baud_rstn=1 at T+2; o_pending stays 0.
- i_tx_busy=1, write 100, then write 200 → o_pending=1 and o_baud_sel=433 held; drop busy at U → o_baud_sel=200 at U+1, one restart pulse.
- Idle, write 1 → o_baud_sel=3 (clamped to MIN_DIV).
- UART_AUTOBAUD_EN, i_ab_start, line high, then low for 434 cycles → o_ab_done=1 with o_ab_err=0; o_baud_sel=433 applied next cycle.
- UART_AUTOBAUD_EN, low pulse of 2 cycles → o_ab_done=1 with o_ab_err=1; o_baud_sel unchanged; o_pending=0.
